motor_step_gen: RTL and testbench
=================================

# motor_step_gen

Step/direction pulse generator sitting directly downstream of the MOTOR_AXI AXI4-Lite register file in the motor2 peripheral. It consumes the software-programmed direction, step count and step period, plus a one-cycle start strobe raised when the control register is written. From these it drives the external driver's STEP and DIR pins with a guaranteed DIR setup time and fixed STEP pulse width. Status (busy, done, steps issued, config error) is fed back to the register file for readback.

## Interface
- CNT_WIDTH, 32, width of step count, period and progress counters
- PULSE_WIDTH, 10, STEP high time in ACLK cycles (≥1)
- DIR_SETUP, 5, cycles between DIR update and first STEP rising edge (≥1)

- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  reset; one clock; synchronous, active-low
- start  in  1  one-cycle strobe: latch config and begin a move
- abort  in  1  one-cycle strobe: terminate move in progress
- cfg_dir  in  1  requested direction (1 = forward)
- cfg_steps  in  CNT_WIDTH  number of STEP pulses to issue
- cfg_period  in  CNT_WIDTH  STEP period in ACLK cycles
- step_out  out  1  STEP pin, registered
- dir_out  out  1  DIR pin, registered
- busy  out  1  move in progress
- done  out  1  one-cycle pulse at end of move (normal or aborted)
- step_count  out  CNT_WIDTH  STEP pulses issued in current/last move
- cfg_err  out  1  sticky: last accepted period was below PULSE_WIDTH+1 and was clamped

## Operation
- States: IDLE, SETUP, HIGH, LOW.
- Reset (ARESETN=0 at an edge): state IDLE, all outputs 0, internal counters 0.
- IDLE, start=1, abort=0: latch cfg_dir, cfg_steps, effective period Pe = max(cfg_period, PULSE_WIDTH+1). Set cfg_err = (cfg_period < PULSE_WIDTH+1). Clear step_count. Set dir_out=cfg_dir.
  - If cfg_steps=0: stay IDLE, assert done for one cycle, busy stays 0.
  - Otherwise: busy=1, go to SETUP.
- SETUP: hold for DIR_SETUP cycles, then go to HIGH. On entry to HIGH: step_out=1 and step_count+1.
- HIGH: hold PULSE_WIDTH cycles, then go to LOW with step_out=0.
- LOW: hold Pe−PULSE_WIDTH cycles. Then:
  - if step_count < latched steps: go to HIGH (step_out=1, step_count+1);
  - else: go to IDLE with busy=0 and done=1 for one cycle.
- abort=1 while busy (SETUP/HIGH/LOW): next edge goes to IDLE, step_out=0, busy=0, done=1. step_count holds the pulses already issued (a truncated HIGH still counts). dir_out holds.
- start while busy is ignored; latched config is unchanged.
- start and abort in the same IDLE cycle: abort wins, start is ignored, no done.
- dir_out changes only on an accepted start, never mid-move.
- cfg_err is cleared only by reset or by an accepted start with a valid period.
- Counters are unsigned, CNT_WIDTH wide. cfg_steps = 2^CNT_WIDTH−1 is legal; step_count never wraps.

## Timing
- Start sampled at edge E0. At E0 the outputs update: busy=1, dir_out=cfg_dir.
- First STEP rising edge is at E0+DIR_SETUP.
- Step k (1-based) rises at E0+DIR_SETUP+(k−1)·Pe and is high for exactly PULSE_WIDTH cycles.
- Move of N steps: busy high for DIR_SETUP+N·Pe cycles. done is high for the single cycle after busy falls.
- Latency abort→step_out low/busy low/done: 1 edge.
- cfg_steps=0 start: done 1 edge after start; step_out never toggles.
- Reset mid-move: at the reset edge all outputs drop to 0, with no done pulse.

## Test plan
- Basic move: steps=3, period=20, dir=1, defaults. Required: dir_out=1 at E0; STEP rises at E0+5, +25, +45, each 10 cycles high; busy 65 cycles; single done; step_count=3.
- Clamp: period=4, steps=2. Required: cfg_err=1; effective period 11; rises at E0+5 and E0+16; step_count=2.
- Zero steps: steps=0. Required: done one cycle after start, busy never 1, step_out stays 0, step_count=0.
- Abort mid-pulse: steps=5, period=20, abort 3 cycles into step 2's HIGH. Required: next cycle step_out=0, busy=0, done=1, step_count=2; dir_out held.
- Collisions: start during a busy move is ignored (direction and count unchanged). start+abort in the same IDLE cycle produces no busy and no done.
- Reset mid-move: ARESETN low during LOW of step 2. Required: all outputs 0 after the edge, no done; a new start afterwards runs a normal move.

Source files
------------

// File: rtl/motor_step_gen.sv
// motor_step_gen: STEP/DIR pulse generator for the motor2 peripheral.
// Enforces DIR setup time, fixed STEP width and a minimum step period.
module motor_step_gen #(
   parameter int CNT_WIDTH   = 32,
   parameter int PULSE_WIDTH = 10,
   parameter int DIR_SETUP   = 5
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 cfg_dir,
   input  logic [CNT_WIDTH-1:0] cfg_steps,
   input  logic [CNT_WIDTH-1:0] cfg_period,
   output logic                 step_out,
   output logic                 dir_out,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] step_count,
   output logic                 cfg_err
);

   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

   localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] PW      = CNT_WIDTH'(PULSE_WIDTH);
   localparam logic [CNT_WIDTH-1:0] MIN_PER = CNT_WIDTH'(PULSE_WIDTH + 1);
   localparam logic [CNT_WIDTH-1:0] DS_END  = CNT_WIDTH'(DIR_SETUP - 1);
   localparam logic [CNT_WIDTH-1:0] PW_END  = CNT_WIDTH'(PULSE_WIDTH - 1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] steps_q, steps_d;
   logic [CNT_WIDTH-1:0] low_q, low_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 step_q, step_d;
   logic                 dir_q, dir_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 short_per;
   logic [CNT_WIDTH-1:0] per_eff;

   assign short_per = cfg_period < MIN_PER;
   assign per_eff   = short_per ? MIN_PER : cfg_period;

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         steps_q <= '0;
         low_q   <= '0;
         count_q <= '0;
         step_q  <= 1'b0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         steps_q <= steps_d;
         low_q   <= low_d;
         count_q <= count_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + ONE;
      steps_d = steps_q;
      low_d   = low_q;
      count_d = count_q;
      step_d  = step_q;
      dir_d   = dir_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start && !abort) begin
               dir_d   = cfg_dir;
               steps_d = cfg_steps;
               err_d   = short_per;
               low_d   = per_eff - PW;
               count_d = '0;
               if (cfg_steps == '0) begin
                  done_d = 1'b1;
               end else begin
                  busy_d  = 1'b1;
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            if (cnt_q == DS_END) begin
               state_d = HIGH;
               cnt_d   = '0;
               step_d  = 1'b1;
               count_d = count_q + ONE;
            end
         end
         HIGH: begin
            if (cnt_q == PW_END) begin
               state_d = LOW;
               cnt_d   = '0;
               step_d  = 1'b0;
            end
         end
         LOW: begin
            if (cnt_q == low_q - ONE) begin
               cnt_d = '0;
               if (count_q < steps_q) begin
                  state_d = HIGH;
                  step_d  = 1'b1;
                  count_d = count_q + ONE;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // abort ends any active move; a cut-short pulse stays counted
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = '0;
         step_d  = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b1;
         count_d = count_q;
      end
   end

   assign step_out   = step_q;
   assign dir_out    = dir_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign step_count = count_q;
   assign cfg_err    = err_q;

endmodule

// File: tb/tb_motor_step_gen.sv
// tb_motor_step_gen: directed checks of motor_step_gen timing,
// clamping, abort, collisions and reset behaviour.
module tb_motor_step_gen;

   localparam int CW = 32;
   localparam int PW = 10;
   localparam int DS = 5;

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic          start;
   logic          abort;
   logic          cfg_dir;
   logic [CW-1:0] cfg_steps;
   logic [CW-1:0] cfg_period;
   logic          step_out;
   logic          dir_out;
   logic          busy;
   logic          done;
   logic [CW-1:0] step_count;
   logic          cfg_err;

   int nchecks = 0;
   int nerrors = 0;

   always #5 ACLK = ~ACLK;

   motor_step_gen #(
      .CNT_WIDTH  (CW),
      .PULSE_WIDTH(PW),
      .DIR_SETUP  (DS)
   ) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .start     (start),
      .abort     (abort),
      .cfg_dir   (cfg_dir),
      .cfg_steps (cfg_steps),
      .cfg_period(cfg_period),
      .step_out  (step_out),
      .dir_out   (dir_out),
      .busy      (busy),
      .done      (done),
      .step_count(step_count),
      .cfg_err   (cfg_err)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Launch a move and compare every cycle with the ideal waveform.
   // inj_t >= 0 injects a conflicting start after cycle inj_t.
   task automatic run_move(input logic dir, input int steps, input int period,
                           input int pe, input logic err, input int inj_t);
      int last;
      cfg_dir    = dir;
      cfg_steps  = CW'(steps);
      cfg_period = CW'(period);
      start      = 1'b1;
      abort      = 1'b0;
      tick();
      start = 1'b0;
      last  = DS + steps * pe;
      check("err_at_start", cfg_err, err);
      for (int t = 0; t <= last + 1; t++) begin
         int   rises;
         logic hi;
         rises = 0;
         hi    = 1'b0;
         for (int k = 0; k < steps; k++) begin
            int r;
            r = DS + k * pe;
            if (r <= t) rises++;
            if (t >= r && t < r + PW) hi = 1'b1;
         end
         check("step", step_out, hi);
         check("busy", busy, t < last);
         check("done", done, t == last);
         check("count", step_count, rises);
         check("dir", dir_out, dir);
         if (t == inj_t) begin
            cfg_dir    = ~dir;
            cfg_steps  = 1;
            cfg_period = 30;
            start      = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check("err_end", cfg_err, err);
      check("final_count", step_count, steps);
   endtask

   initial begin
      ARESETN    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      cfg_dir    = 1'b0;
      cfg_steps  = '0;
      cfg_period = '0;
      repeat (3) tick();
      check("rst_step", step_out, 0);
      check("rst_dir", dir_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", step_count, 0);
      check("rst_err", cfg_err, 0);
      ARESETN = 1'b1;
      tick();

      // basic move and period clamping
      run_move(1'b1, 3, 20, 20, 1'b0, -1);
      run_move(1'b0, 2, 4, 11, 1'b1, -1);
      run_move(1'b1, 1, 11, 11, 1'b0, -1);

      // zero steps
      cfg_dir    = 1'b1;
      cfg_steps  = 0;
      cfg_period = 20;
      start      = 1'b1;
      tick();
      start = 1'b0;
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_step", step_out, 0);
      check("zero_count", step_count, 0);
      check("zero_dir", dir_out, 1);
      tick();
      check("zero_done2", done, 0);
      check("zero_busy2", busy, 0);
      check("zero_step2", step_out, 0);

      // abort 3 cycles into step 2 high time
      cfg_dir    = 1'b0;
      cfg_steps  = 5;
      cfg_period = 20;
      start      = 1'b1;
      tick();
      start = 1'b0;
      repeat (27) tick();
      check("ab_pre_step", step_out, 1);
      check("ab_pre_count", step_count, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_step", step_out, 0);
      check("ab_busy", busy, 0);
      check("ab_done", done, 1);
      check("ab_count", step_count, 2);
      check("ab_dir", dir_out, 0);
      tick();
      check("ab_done2", done, 0);
      check("ab_count2", step_count, 2);

      // start during a move is ignored
      run_move(1'b1, 4, 12, 12, 1'b0, 10);

      // start with abort in idle does nothing
      cfg_dir    = 1'b0;
      cfg_steps  = 3;
      cfg_period = 20;
      start      = 1'b1;
      abort      = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", busy, 0);
      check("sa_done", done, 0);
      check("sa_dir", dir_out, 1);
      check("sa_count", step_count, 4);
      tick();
      check("sa_busy2", busy, 0);
      check("sa_done2", done, 0);
      check("sa_step2", step_out, 0);

      // reset during low phase of step 2
      cfg_dir    = 1'b1;
      cfg_steps  = 3;
      cfg_period = 20;
      start      = 1'b1;
      tick();
      start = 1'b0;
      repeat (38) tick();
      check("rm_pre_step", step_out, 0);
      check("rm_pre_busy", busy, 1);
      check("rm_pre_count", step_count, 2);
      ARESETN = 1'b0;
      tick();
      check("rm_step", step_out, 0);
      check("rm_dir", dir_out, 0);
      check("rm_busy", busy, 0);
      check("rm_done", done, 0);
      check("rm_count", step_count, 0);
      check("rm_err", cfg_err, 0);
      ARESETN = 1'b1;
      tick();
      check("rm_done2", done, 0);
      check("rm_busy2", busy, 0);
      run_move(1'b0, 2, 15, 15, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
